// File: rtl/vpu_scratchpad.sv
// rtl/vpu_scratchpad.sv - VPU operand scratchpad with dual read, result write and host preload
//
// Purpose:
//   Operand store behind the VPU memory interface. It serves one dual-operand read
//   (A and B) at a time with a fixed latency, single result writes (C), and host
//   preload writes. After every reset a hardware sweep clears all entries before
//   any request is accepted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_req, addr_a, addr_b   read request and operand addresses (taken when mem_rdy)
//   wr_req, addr_c, data_c   result write (taken when mem_rdy)
//   mem_rdy                  request can be accepted this cycle
//   mem_valid, data_a/b      one-cycle read-result pulse; data held otherwise
//   ld_en, ld_addr, ld_data  host preload request
//   ld_rdy                   host preload accepted this cycle
//   addr_err                 sticky out-of-range address flag
module vpu_scratchpad #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [DATA_W-1:0] data_c,
  output logic              mem_rdy,
  output logic              mem_valid,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_rdy,
  output logic              addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_READ = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  clr_cnt_q;
  logic [2:0]        lat_cnt_q;
  logic [DATA_W-1:0] cap_a_q, cap_b_q;
  logic [DATA_W-1:0] data_a_q, data_b_q;
  logic              mem_valid_q;
  logic              addr_err_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(DEPTH);
  endfunction

  logic rd_acc, wr_acc, ld_acc;
  logic wr_ok, ld_ok, err_set;

  assign mem_rdy   = (state_q == ST_IDLE);
  // The VPU result write owns the single write port when both ask in the same cycle.
  assign ld_rdy    = ld_en && (state_q != ST_INIT) && !(wr_req && mem_rdy);
  assign mem_valid = mem_valid_q;
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign addr_err  = addr_err_q;

  assign rd_acc  = rd_req && mem_rdy;
  assign wr_acc  = wr_req && mem_rdy;
  assign ld_acc  = ld_en && ld_rdy;
  assign wr_ok   = wr_acc && in_range(addr_c);
  assign ld_ok   = ld_acc && in_range(ld_addr);
  assign err_set = (rd_acc && (!in_range(addr_a) || !in_range(addr_b)))
                 || (wr_acc && !in_range(addr_c))
                 || (ld_acc && !in_range(ld_addr));

  // Read operands as seen at the accept edge. A result write committing on the same
  // edge is forwarded (write-first); a preload on that edge is not visible.
  logic [DATA_W-1:0] rd_a_val, rd_b_val;

  always_comb begin
    rd_a_val = '0;
    if (in_range(addr_a)) begin
      if (wr_ok && (addr_c == addr_a)) rd_a_val = data_c;
      else                             rd_a_val = mem_q[addr_a[IDX_W-1:0]];
    end
  end

  always_comb begin
    rd_b_val = '0;
    if (in_range(addr_b)) begin
      if (wr_ok && (addr_c == addr_b)) rd_b_val = data_c;
      else                             rd_b_val = mem_q[addr_b[IDX_W-1:0]];
    end
  end

  // Single write port: sweep, then result write, then preload.
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
      end else if (wr_ok) begin
        mem_we    = 1'b1;
        mem_waddr = addr_c[IDX_W-1:0];
        mem_wdata = data_c;
      end else if (ld_ok) begin
        mem_we    = 1'b1;
        mem_waddr = ld_addr[IDX_W-1:0];
        mem_wdata = ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      mem_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      mem_valid_q <= 1'b0;
      if (err_set) addr_err_q <= 1'b1;
      case (state_q)
        ST_INIT: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (rd_acc) begin
            lat_cnt_q <= 3'(RD_LAT);
            cap_a_q   <= rd_a_val;
            cap_b_q   <= rd_b_val;
            state_q   <= ST_READ;
            // With a latency of one the result is presented straight after accept.
            if (RD_LAT == 1) begin
              mem_valid_q <= 1'b1;
              data_a_q    <= rd_a_val;
              data_b_q    <= rd_b_val;
            end
          end
        end
        ST_READ: begin
          lat_cnt_q <= lat_cnt_q - 1'b1;
          // Loading outputs as the counter steps to 1 makes mem_valid coincide with lat_cnt==1.
          if (lat_cnt_q == 3'd2) begin
            mem_valid_q <= 1'b1;
            data_a_q    <= cap_a_q;
            data_b_q    <= cap_b_q;
          end
          if (lat_cnt_q == 3'd1) state_q <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_scratchpad.sv
// tb/tb_vpu_scratchpad.sv - self-checking bench for vpu_scratchpad
module tb_vpu_scratchpad;

  localparam int DEPTH  = 32;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [15:0] addr_a = '0;
  logic [15:0] addr_b = '0;
  logic        wr_req = 1'b0;
  logic [15:0] addr_c = '0;
  logic [31:0] data_c = '0;
  logic        mem_rdy;
  logic        mem_valid;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_rdy;
  logic        addr_err;

  vpu_scratchpad #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .addr_a(addr_a), .addr_b(addr_b),
    .wr_req(wr_req), .addr_c(addr_c), .data_c(data_c),
    .mem_rdy(mem_rdy), .mem_valid(mem_valid), .data_a(data_a), .data_b(data_b),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_rdy(ld_rdy),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: time-stamped availability windows plus a plain array.
  int          cyc       = 0;
  int          init_end  = 1 << 30;
  int          ready_at  = 1 << 30;
  int          valid_at  = 0;
  bit          read_pend = 0;
  bit          m_err     = 0;
  logic [31:0] mm [DEPTH];
  logic [31:0] pend_a = '0, pend_b = '0, hold_a = '0, hold_b = '0;

  function automatic logic [31:0] m_rd_val(input logic [15:0] a, input bit wa);
    if (a >= 16'(DEPTH)) return 32'h0;
    if (wa && addr_c == a) return data_c;
    return mm[a[4:0]];
  endfunction

  always @(posedge clk) begin
    int e;
    bit rdy, wa;
    e = cyc + 1;
    if (rst) begin
      init_end  = e + DEPTH;
      ready_at  = e + DEPTH;
      read_pend = 0;
      m_err     = 0;
      hold_a    = '0;
      hold_b    = '0;
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    end else begin
      rdy = (cyc >= ready_at);
      wa  = wr_req && rdy;
      if (rd_req && rdy) begin
        pend_a    = m_rd_val(addr_a, wa);
        pend_b    = m_rd_val(addr_b, wa);
        read_pend = 1;
        valid_at  = e + RD_LAT - 1;
        ready_at  = e + RD_LAT;
        if (addr_a >= 16'(DEPTH) || addr_b >= 16'(DEPTH)) m_err = 1;
      end
      if (wa) begin
        if (addr_c < 16'(DEPTH)) mm[addr_c[4:0]] = data_c;
        else m_err = 1;
      end
      if (ld_en && cyc >= init_end && !wa) begin
        if (ld_addr < 16'(DEPTH)) mm[ld_addr[4:0]] = ld_data;
        else m_err = 1;
      end
      if (read_pend && e == valid_at) begin
        hold_a = pend_a;
        hold_b = pend_b;
      end
    end
    cyc = e;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("mdl_mem_rdy",   32'(mem_rdy),   32'(cyc >= ready_at));
      chk("mdl_mem_valid", 32'(mem_valid), 32'(read_pend && cyc == valid_at));
      chk("mdl_ld_rdy",    32'(ld_rdy),
          32'(ld_en && cyc >= init_end && !(wr_req && cyc >= ready_at)));
      chk("mdl_addr_err",  32'(addr_err),  32'(m_err));
      chk("mdl_data_a",    data_a,         hold_a);
      chk("mdl_data_b",    data_b,         hold_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_init(output int n, output bit saw_valid);
    n = 0;
    saw_valid = 0;
    while (!mem_rdy && n < 100) begin
      if (mem_valid) saw_valid = 1;
      n++;
      tick();
    end
  endtask

  // Issues a read (along with whatever write/preload inputs the caller set) and
  // returns the result and the request-to-mem_valid latency.
  task automatic do_read(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] da, output logic [31:0] db, output int lat);
    rd_req = 1'b1;
    addr_a = a;
    addr_b = b;
    tick();
    rd_req = 1'b0;
    wr_req = 1'b0;
    ld_en  = 1'b0;
    lat = 1;
    while (!mem_valid && lat < 20) begin
      tick();
      lat++;
    end
    da = data_a;
    db = data_b;
    tick();
  endtask

  task automatic read_chk(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] ea, input logic [31:0] eb);
    logic [31:0] da, db;
    int lat;
    do_read(a, b, da, db, lat);
    chk({name, "_lat"}, 32'(lat), 32'd2);
    chk({name, "_a"}, da, ea);
    chk({name, "_b"}, db, eb);
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    #1;
    chk("preload_ld_rdy", 32'(ld_rdy), 32'd1);
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    int n;
    bit saw;

    // 1) reset, sweep length, all entries zero
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("reset_addr_err",  32'(addr_err),  32'd0);
    chk("reset_data_a",    data_a,         32'd0);
    wait_init(n, saw);
    chk("init_rdy_low_cycles", 32'(n), 32'd32);
    chk("init_no_valid", 32'(saw), 32'd0);
    for (int i = 0; i < DEPTH; i++) read_chk("sweep_zero", 16'(i), 16'(DEPTH - 1 - i), 0, 0);

    // 2) preload then read same address on both operands
    preload(16'd5, 32'hDEADBEEF);
    read_chk("preload5", 16'd5, 16'd5, 32'hDEADBEEF, 32'hDEADBEEF);

    // 3) write-first on simultaneous write and read
    preload(16'd4, 32'h77);
    wr_req = 1'b1;
    addr_c = 16'd3;
    data_c = 32'h1234;
    read_chk("write_first", 16'd3, 16'd4, 32'h1234, 32'h77);

    // 4) write beats preload; preload lands a cycle later, after the read captured
    ld_en   = 1'b1;
    ld_addr = 16'd7;
    ld_data = 32'hAAAA5555;
    wr_req  = 1'b1;
    addr_c  = 16'd7;
    data_c  = 32'h0BADF00D;
    #1;
    chk("wr_vs_ld_ld_rdy", 32'(ld_rdy), 32'd0);
    tick();
    wr_req = 1'b0;
    #1;
    chk("ld_retry_ld_rdy", 32'(ld_rdy), 32'd1);
    read_chk("entry7_wr", 16'd7, 16'd7, 32'h0BADF00D, 32'h0BADF00D);
    read_chk("entry7_ld", 16'd7, 16'd3, 32'hAAAA5555, 32'h1234);

    // 5) out-of-range accesses
    chk("err_before_oor", 32'(addr_err), 32'd0);
    preload(16'd0, 32'h5A5A5A5A);
    read_chk("oor_read", 16'h0020, 16'd0, 32'd0, 32'h5A5A5A5A);
    chk("err_after_oor", 32'(addr_err), 32'd1);
    wr_req = 1'b1;
    addr_c = 16'h0020;
    data_c = 32'hFFFFFFFF;
    tick();
    wr_req = 1'b0;
    ld_en   = 1'b1;
    ld_addr = 16'h8000;
    ld_data = 32'h11111111;
    tick();
    ld_en = 1'b0;
    read_chk("entry0_kept", 16'd0, 16'd5, 32'h5A5A5A5A, 32'hDEADBEEF);
    chk("err_sticky", 32'(addr_err), 32'd1);

    // 6) reset one cycle after a read is accepted
    rd_req = 1'b1;
    addr_a = 16'd5;
    addr_b = 16'd0;
    tick();
    rd_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init(n, saw);
    chk("rerun_rdy_low_cycles", 32'(n), 32'd32);
    chk("abort_no_valid", 32'(saw), 32'd0);
    chk("rerun_addr_err", 32'(addr_err), 32'd0);
    chk("rerun_data_a", data_a, 32'd0);
    for (int i = 0; i < DEPTH; i++) read_chk("resweep_zero", 16'(i), 16'(i), 0, 0);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
